// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller sequencing start, data, parity and stop bits.
// Define UART_RX_PARITY_SUPPORT_EN to build the optional parity bit handling.
module uart_rx_fsm #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RX_IN,
    input  logic [3:0] Prescale,
    input  logic       Parity_EN,
    input  logic [3:0] Bit_count,
    input  logic [2:0] Edge_count,
    input  logic       Strt_glitch,
    input  logic       Par_err_in,
    input  logic       Stop_err_in,
    output logic       Counter_EN,
    output logic       Sampler_EN,
    output logic       Deser_EN,
    output logic       Strt_chk_EN,
    output logic       Par_chk_EN,
    output logic       Stop_chk_EN,
    output logic       Data_valid,
    output logic       Parity_err,
    output logic       Framing_err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_RX_PARITY_SUPPORT_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4,
        StDone   = 3'd5
    } state_e;

    typedef struct packed {
        logic counter;
        logic sampler;
        logic deser;
        logic strt_chk;
`ifdef UART_RX_PARITY_SUPPORT_EN
        logic par_chk;
`endif
        logic stop_chk;
    } en_t;

    localparam logic [3:0] LastDataBit = 4'(DATA_BITS);

    // Enables are registered alongside the state, so each transition loads the target's set.
    function automatic en_t en_for(input state_e s);
        en_t e;
        e = '0;
        case (s)
            StStart: begin
                e.counter  = 1'b1;
                e.sampler  = 1'b1;
                e.strt_chk = 1'b1;
            end
            StData: begin
                e.counter = 1'b1;
                e.sampler = 1'b1;
                e.deser   = 1'b1;
            end
`ifdef UART_RX_PARITY_SUPPORT_EN
            StParity: begin
                e.counter = 1'b1;
                e.sampler = 1'b1;
                e.par_chk = 1'b1;
            end
`endif
            StStop: begin
                e.counter  = 1'b1;
                e.sampler  = 1'b1;
                e.stop_chk = 1'b1;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    state_e     state_q;
    en_t        en_q;
    logic [3:0] prescale_q;
    logic       prescale_ok;
    logic       start_ok;
    logic       last_edge;
    logic       data_done;

`ifdef UART_RX_PARITY_SUPPORT_EN
    logic parity_en_q;
    logic par_flag_q;
`else
    logic unused_parity_inputs;
    assign unused_parity_inputs = Parity_EN | Par_err_in;
`endif

    assign prescale_ok = (Prescale >= 4'd4) && (Prescale <= 4'd8);
    assign start_ok    = !RX_IN && prescale_ok;
    assign last_edge   = ({1'b0, Edge_count} == (prescale_q - 4'd1));
    assign data_done   = last_edge && (Bit_count == LastDataBit);

    assign Counter_EN  = en_q.counter;
    assign Sampler_EN  = en_q.sampler;
    assign Deser_EN    = en_q.deser;
    assign Strt_chk_EN = en_q.strt_chk;
    assign Stop_chk_EN = en_q.stop_chk;
`ifdef UART_RX_PARITY_SUPPORT_EN
    assign Par_chk_EN  = en_q.par_chk;
`else
    assign Par_chk_EN  = 1'b0;
    assign Parity_err  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            en_q        <= '0;
            prescale_q  <= '0;
            Data_valid  <= 1'b0;
            Framing_err <= 1'b0;
`ifdef UART_RX_PARITY_SUPPORT_EN
            parity_en_q <= 1'b0;
            par_flag_q  <= 1'b0;
            Parity_err  <= 1'b0;
`endif
        end else begin
            Data_valid  <= 1'b0;
            Framing_err <= 1'b0;
`ifdef UART_RX_PARITY_SUPPORT_EN
            Parity_err  <= 1'b0;
`endif
            case (state_q)
                // An illegal Prescale would never reach a last edge, so DONE also refuses it.
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q    <= StStart;
                        en_q       <= en_for(StStart);
                        prescale_q <= Prescale;
`ifdef UART_RX_PARITY_SUPPORT_EN
                        parity_en_q <= Parity_EN;
                        par_flag_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= StIdle;
                        en_q    <= en_for(StIdle);
                    end
                end
                StStart: begin
                    if (last_edge) begin
                        if (Strt_glitch) begin
                            state_q <= StIdle;
                            en_q    <= en_for(StIdle);
                        end else begin
                            state_q <= StData;
                            en_q    <= en_for(StData);
                        end
                    end
                end
                StData: begin
                    if (data_done) begin
`ifdef UART_RX_PARITY_SUPPORT_EN
                        if (parity_en_q) begin
                            state_q <= StParity;
                            en_q    <= en_for(StParity);
                        end else begin
                            state_q <= StStop;
                            en_q    <= en_for(StStop);
                        end
`else
                        state_q <= StStop;
                        en_q    <= en_for(StStop);
`endif
                    end
                end
`ifdef UART_RX_PARITY_SUPPORT_EN
                StParity: begin
                    if (last_edge) begin
                        par_flag_q <= Par_err_in;
                        state_q    <= StStop;
                        en_q       <= en_for(StStop);
                    end
                end
`endif
                StStop: begin
                    if (last_edge) begin
                        state_q     <= StDone;
                        en_q        <= en_for(StDone);
                        Framing_err <= Stop_err_in;
`ifdef UART_RX_PARITY_SUPPORT_EN
                        Parity_err  <= par_flag_q;
                        Data_valid  <= !Stop_err_in && !par_flag_q;
`else
                        Data_valid  <= !Stop_err_in;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    en_q    <= en_for(StIdle);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed scenarios for uart_rx_fsm with a behavioural edge/bit counter.
module tb_uart_rx_fsm;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [3:0] Prescale = 4'd8;
    logic       Parity_EN = 1'b0;
    logic [3:0] Bit_count = '0;
    logic [2:0] Edge_count = '0;
    logic       Strt_glitch = 1'b0;
    logic       Par_err_in = 1'b0;
    logic       Stop_err_in = 1'b0;
    logic       Counter_EN, Sampler_EN, Deser_EN, Strt_chk_EN, Par_chk_EN, Stop_chk_EN;
    logic       Data_valid, Parity_err, Framing_err;

    logic [3:0] cnt_ps = 4'd8;
    logic [5:0] en_vec;
    logic [5:0] en_log [0:255];
    int         vectors = 0;
    int         miscompares = 0;

    uart_rx_fsm #(.DATA_BITS(8)) dut (
        .Clk(Clk), .Rst(Rst), .RX_IN(RX_IN), .Prescale(Prescale), .Parity_EN(Parity_EN),
        .Bit_count(Bit_count), .Edge_count(Edge_count), .Strt_glitch(Strt_glitch),
        .Par_err_in(Par_err_in), .Stop_err_in(Stop_err_in), .Counter_EN(Counter_EN),
        .Sampler_EN(Sampler_EN), .Deser_EN(Deser_EN), .Strt_chk_EN(Strt_chk_EN),
        .Par_chk_EN(Par_chk_EN), .Stop_chk_EN(Stop_chk_EN), .Data_valid(Data_valid),
        .Parity_err(Parity_err), .Framing_err(Framing_err)
    );

    always #5 Clk = ~Clk;

    assign en_vec = {Counter_EN, Sampler_EN, Deser_EN, Strt_chk_EN, Par_chk_EN, Stop_chk_EN};

    // Neighbouring edge/bit counter; cnt_ps is held per frame independent of Prescale.
    always @(posedge Clk) begin
        if (!Counter_EN) begin
            Edge_count <= '0;
            Bit_count  <= '0;
        end else if ({1'b0, Edge_count} == cnt_ps - 4'd1) begin
            Edge_count <= '0;
            Bit_count  <= Bit_count + 4'd1;
        end else begin
            Edge_count <= Edge_count + 3'd1;
        end
    end

    // Launches one frame from IDLE; lat is the cycle of the result pulse, 0 when no pulse occurs.
    task automatic run_frame(input logic [3:0] ps, input logic par_en, input logic perr,
                             input logic serr, input logic mid_change, output int lat,
                             output logic dv, output logic pe, output logic fe);
        Prescale    = ps;
        cnt_ps      = ps;
        Parity_EN   = par_en;
        Par_err_in  = perr;
        Stop_err_in = serr;
        Strt_glitch = 1'b0;
        RX_IN       = 1'b0;
        lat = 0;
        dv  = 1'b0;
        pe  = 1'b0;
        fe  = 1'b0;
        @(negedge Clk);
        RX_IN = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            en_log[c] = en_vec;
            if (mid_change && c == 20) begin
                Prescale  = 4'd4;
                Parity_EN = ~par_en;
            end
            if (Data_valid || Parity_err || Framing_err) begin
                lat = c;
                dv  = Data_valid;
                pe  = Parity_err;
                fe  = Framing_err;
                break;
            end
            @(negedge Clk);
        end
        Prescale  = ps;
        Parity_EN = par_en;
    endtask

    task automatic test_reset();
        logic seen;
        Rst = 1'b1;
        RX_IN = 1'b0;
        Prescale = 4'd8;
        repeat (3) @(negedge Clk);
        vectors++;
        if (en_vec !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_enables: got %b expected %b", en_vec, 6'b0);
        end
        vectors++;
        if ({Data_valid, Parity_err, Framing_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_results: got %b expected 000",
                     {Data_valid, Parity_err, Framing_err});
        end
        RX_IN = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            seen |= Counter_EN;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_hold: Counter_EN seen %b expected 0", seen);
        end
    endtask

    task automatic test_good_frame();
        int lat;
        logic dv, pe, fe;
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, lat, dv, pe, fe);
        vectors++;
        if (lat !== 81) begin
            miscompares++;
            $display("FAIL good_latency: got %0d expected 81", lat);
        end
        vectors++;
        if ({dv, pe, fe} !== 3'b100) begin
            miscompares++;
            $display("FAIL good_results: dv/pe/fe got %b expected 100", {dv, pe, fe});
        end
        vectors++;
        if (en_log[1] !== 6'b110100) begin
            miscompares++;
            $display("FAIL start_enables: got %b expected 110100", en_log[1]);
        end
        vectors++;
        if (en_log[9] !== 6'b111000) begin
            miscompares++;
            $display("FAIL data_enables: got %b expected 111000", en_log[9]);
        end
        vectors++;
        if (en_log[73] !== 6'b110001) begin
            miscompares++;
            $display("FAIL stop_enables: got %b expected 110001", en_log[73]);
        end
        vectors++;
        if (en_log[81] !== 6'b000000) begin
            miscompares++;
            $display("FAIL done_enables: got %b expected 000000", en_log[81]);
        end
        @(negedge Clk);
        vectors++;
        if ({Data_valid, Counter_EN} !== 2'b00) begin
            miscompares++;
            $display("FAIL pulse_single: dv/cen got %b expected 00", {Data_valid, Counter_EN});
        end
    endtask

    task automatic test_framing_error();
        int lat;
        logic dv, pe, fe;
        run_frame(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, lat, dv, pe, fe);
        vectors++;
        if (lat !== 51) begin
            miscompares++;
            $display("FAIL framing_latency: got %0d expected 51", lat);
        end
        vectors++;
        if ({dv, pe, fe} !== 3'b001) begin
            miscompares++;
            $display("FAIL framing_results: dv/pe/fe got %b expected 001", {dv, pe, fe});
        end
        @(negedge Clk);
    endtask

    task automatic test_parity();
        int lat;
        logic dv, pe, fe;
`ifdef UART_RX_PARITY_SUPPORT_EN
        run_frame(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, lat, dv, pe, fe);
        vectors++;
        if (lat !== 45) begin
            miscompares++;
            $display("FAIL parity_latency: got %0d expected 45", lat);
        end
        vectors++;
        if ({dv, pe, fe} !== 3'b010) begin
            miscompares++;
            $display("FAIL parity_results: dv/pe/fe got %b expected 010", {dv, pe, fe});
        end
        vectors++;
        if (en_log[37] !== 6'b110010) begin
            miscompares++;
            $display("FAIL parity_enables: got %b expected 110010", en_log[37]);
        end
        @(negedge Clk);
        run_frame(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, lat, dv, pe, fe);
        vectors++;
        if ({lat, dv, pe, fe} !== {32'd45, 3'b100}) begin
            miscompares++;
            $display("FAIL parity_good: lat %0d dv/pe/fe %b expected 45 100", lat, {dv, pe, fe});
        end
`else
        run_frame(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, lat, dv, pe, fe);
        vectors++;
        if (lat !== 81) begin
            miscompares++;
            $display("FAIL noparity_latency: got %0d expected 81", lat);
        end
        vectors++;
        if ({dv, pe, fe} !== 3'b100) begin
            miscompares++;
            $display("FAIL noparity_results: dv/pe/fe got %b expected 100", {dv, pe, fe});
        end
        vectors++;
        if (en_log[73] !== 6'b110001) begin
            miscompares++;
            $display("FAIL noparity_stop_enables: got %b expected 110001", en_log[73]);
        end
`endif
        @(negedge Clk);
        Parity_EN  = 1'b0;
        Par_err_in = 1'b0;
    endtask

    task automatic test_mid_change();
        int lat;
        logic dv, pe, fe;
        run_frame(4'd8, 1'b0, 1'b1, 1'b0, 1'b1, lat, dv, pe, fe);
        vectors++;
        if (lat !== 81) begin
            miscompares++;
            $display("FAIL midchange_latency: got %0d expected 81", lat);
        end
        vectors++;
        if ({dv, pe, fe} !== 3'b100) begin
            miscompares++;
            $display("FAIL midchange_results: dv/pe/fe got %b expected 100", {dv, pe, fe});
        end
        @(negedge Clk);
        Par_err_in = 1'b0;
    endtask

    task automatic test_start_glitch();
        logic cen4, cen5, pulses;
        Prescale    = 4'd4;
        cnt_ps      = 4'd4;
        Strt_glitch = 1'b1;
        RX_IN       = 1'b0;
        cen4 = 1'b0;
        cen5 = 1'b1;
        pulses = 1'b0;
        @(negedge Clk);
        RX_IN = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 4) cen4 = Counter_EN;
            if (c == 5) cen5 = Counter_EN;
            pulses |= Data_valid | Parity_err | Framing_err;
            @(negedge Clk);
        end
        vectors++;
        if ({cen4, cen5} !== 2'b10) begin
            miscompares++;
            $display("FAIL glitch_counter_en: cycles 4/5 got %b expected 10", {cen4, cen5});
        end
        vectors++;
        if (pulses !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_no_pulse: got %b expected 0", pulses);
        end
        Strt_glitch = 1'b0;
    endtask

    task automatic test_illegal_prescale();
        logic [3:0] bad [0:1];
        logic seen;
        bad[0] = 4'd3;
        bad[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            Prescale = bad[i];
            RX_IN = 1'b0;
            seen = 1'b0;
            repeat (10) begin
                @(negedge Clk);
                seen |= Counter_EN;
            end
            vectors++;
            if (seen !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_prescale_%0d: Counter_EN seen %b expected 0", bad[i], seen);
            end
            RX_IN = 1'b1;
            @(negedge Clk);
        end
        Prescale = 4'd8;
    endtask

    task automatic test_back_to_back();
        int first, second, npulse;
        logic cen_after;
        Prescale = 4'd8;
        cnt_ps   = 4'd8;
        RX_IN    = 1'b0;
        first = 0;
        second = 0;
        npulse = 0;
        cen_after = 1'b0;
        @(negedge Clk);
        RX_IN = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (first != 0 && c == first + 1) cen_after = Counter_EN;
            if (Data_valid) begin
                npulse++;
                if (npulse == 1) begin
                    first = c;
                    RX_IN = 1'b0;
                end else begin
                    second = c;
                    RX_IN = 1'b1;
                end
            end else begin
                RX_IN = 1'b1;
            end
            @(negedge Clk);
        end
        vectors++;
        if (npulse !== 2) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", npulse);
        end
        vectors++;
        if (first !== 81 || second - first !== 81) begin
            miscompares++;
            $display("FAIL b2b_spacing: first %0d gap %0d expected 81 81", first, second - first);
        end
        vectors++;
        if (cen_after !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_direct_start: Counter_EN after DONE got %b expected 1", cen_after);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        logic dv, pe, fe, found, seen;
        Prescale = 4'd8;
        cnt_ps   = 4'd8;
        RX_IN    = 1'b0;
        found = 1'b0;
        @(negedge Clk);
        RX_IN = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (Deser_EN && Bit_count == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        vectors++;
        if (found !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_reach_data: got %b expected 1", found);
        end
        Rst = 1'b1;
        @(negedge Clk);
        vectors++;
        if ({en_vec, Data_valid, Parity_err, Framing_err} !== 9'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b expected 000000000",
                     {en_vec, Data_valid, Parity_err, Framing_err});
        end
        Rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            seen |= Counter_EN;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle: Counter_EN seen %b expected 0", seen);
        end
        run_frame(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, lat, dv, pe, fe);
        vectors++;
        if ({lat, dv, pe, fe} !== {32'd81, 3'b100}) begin
            miscompares++;
            $display("FAIL rst_mid_recover: lat %0d dv/pe/fe %b expected 81 100", lat, {dv, pe, fe});
        end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_framing_error();
        test_parity();
        test_mid_change();
        test_start_glitch();
        test_illegal_prescale();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-002 Clk  in  1  clock; all state changes on rising edge.
REQ-003 Rst  in  1  reset; synchronous, active-high.
REQ-004 RX_IN  in  1  serial line, already synchronised to Clk; idle level 1.
REQ-005 Prescale  in  4  clock cycles per bit; legal values 4..8.
REQ-006 Parity_EN  in  1  frame carries a parity bit after the data bits.
REQ-007 Bit_count  in  4  bit index from the edge/bit counter: 0 = start bit, 1..DATA_BITS = data bits, then parity, then stop.
REQ-008 Edge_count  in  3  cycle index within the current bit, from the edge/bit counter.
REQ-009 Strt_glitch, Par_err_in, Stop_err_in  in  1 each  checker results; valid once the bit's mid-point sample has been taken.
REQ-010 Counter_EN  out  1  drives the counter Enable.
REQ-011 Sampler_EN, Deser_EN, Strt_chk_EN, Par_chk_EN, Stop_chk_EN  out  1 each  enables for the sampler, deserializer and checkers.
REQ-012 Data_valid, Parity_err, Framing_err  out  1 each  one-cycle end-of-frame result pulses.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and DONE, one-hot or binary encoded.
REQ-014 Last edge (LE) SHALL mean Edge_count == Prescale-1, compared at 4-bit width.
REQ-015 IDLE: all outputs 0; on RX_IN==0 with a legal Prescale -> START; with an illegal Prescale, remain in IDLE.
REQ-016 On the IDLE->START or DONE->START transition, the block SHALL latch Parity_EN and Prescale, and use only the latched values for the whole frame.
REQ-017 START: Counter_EN=1, Sampler_EN=1, Strt_chk_EN=1; at LE, Strt_glitch=1 -> IDLE with no result pulse, else -> DATA.
REQ-018 DATA: Counter_EN=1, Sampler_EN=1, Deser_EN=1; at LE with Bit_count==DATA_BITS, latched parity on -> PARITY, else -> STOP.
REQ-019 PARITY: Counter_EN=1, Sampler_EN=1, Par_chk_EN=1; at LE, capture Par_err_in into an internal flag and go -> STOP.
REQ-020 STOP: Counter_EN=1, Sampler_EN=1, Stop_chk_EN=1; at LE, capture Stop_err_in and go -> DONE.
REQ-021 DONE lasts one cycle, with Counter_EN=0 so the counter clears.
REQ-022 In DONE: Parity_err = parity flag; Framing_err = stop flag; Data_valid = neither flag set.
REQ-023 DONE exit: RX_IN==0 -> START (back-to-back frame, no idle cycle); else -> IDLE.
REQ-024 The error flags SHALL clear on entry to START.
REQ-025 Frame length from IDLE exit to the DONE pulse SHALL be (DATA_BITS+2+P)*Prescale+1 cycles, where P is the latched parity setting.
REQ-026 A change in Prescale or Parity_EN mid-frame SHALL have no effect until the next frame.
REQ-027 In every state, outputs not listed for that state SHALL be 0.

Reset
REQ-028 Rst=1 at a rising edge SHALL force IDLE, all outputs 0 and all flags and latches 0 on that edge, including mid-frame.
REQ-029 After release, the first frame SHALL start only on a fresh RX_IN==0 seen in IDLE.

Configuration
REQ-030 Macro UART_RX_PARITY_SUPPORT_EN, when defined, SHALL build the PARITY state and the parity flag, and Parity_EN SHALL be honoured.
REQ-031 Without that macro: no PARITY state, Parity_EN ignored, Par_chk_EN and Parity_err tied to 0, and DATA always goes -> STOP.

Verification
REQ-032 Prescale=8, parity off, frame 0x55 with good stop: Data_valid pulses once, 81 cycles after START entry; Parity_err=0 and Framing_err=0.
REQ-033 Prescale=4, Parity_EN=1, Par_err_in=1 during PARITY: Parity_err=1 and Data_valid=0 in DONE; latency 45 cycles.
REQ-034 Start glitch (Strt_glitch=1 at START LE): return to IDLE; no output pulses; Counter_EN falls on the next cycle.
REQ-035 Two back-to-back frames with RX_IN=0 during DONE: START follows DONE directly; two Data_valid pulses 81 cycles apart at Prescale=8.
REQ-036 Rst=1 during DATA with Bit_count=4: on the next edge, all outputs 0 and state IDLE; a following good frame at Prescale=8 completes normally.
REQ-037 Prescale=3 with RX_IN=0: stays IDLE and Counter_EN stays 0; with the macro undefined and Parity_EN=1, a frame skips PARITY and takes 81 cycles at Prescale=8.
